alu_cmd_parser: RTL and testbench

- Sits inside top, directly downstream of the UART receiver's AXI-stream byte output (m_axis).
- Frames the received byte stream into command packets: opcode byte, reserved byte, 16-bit little-endian total length, then payload.
- Packs the payload into 32-bit little-endian operand words and presents them, with the opcode, to the ALU/echo datapath on a valid/ready stream.
- Malformed packets are drained and flagged.

---
 rtl/alu_cmd_parser_pkg.sv | 28 ++
 rtl/alu_cmd_parser_if.sv | 28 ++
 rtl/alu_cmd_parser_packer.sv | 59 +++++
 rtl/alu_cmd_parser.sv | 133 +++++++++++++
 tb/tb_alu_cmd_parser.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_cmd_parser_pkg.sv
// alu_cmd_parser shared definitions.
// Opcodes, header constants and parser state.
package alu_cmd_pkg;

  localparam logic [7:0] OP_ECHO = 8'hEC;
  localparam logic [7:0] OP_ADD  = 8'hA0;
  localparam logic [7:0] OP_MUL  = 8'hA1;
  localparam logic [7:0] OP_DIV  = 8'hA2;

  localparam int unsigned HDR_BYTES   = 4;
  localparam int unsigned MIN_ALU_LEN = 12;

  typedef enum logic [2:0] {
    S_OPCODE,
    S_RSVD,
    S_LEN_LO,
    S_LEN_HI,
    S_PAYLOAD,
    S_DRAIN
  } state_t;

  function automatic logic is_valid_opcode(
    input logic [7:0] op
  );
    return op inside {OP_ECHO, OP_ADD, OP_MUL, OP_DIV};
  endfunction

endpackage

// File: rtl/alu_cmd_parser_if.sv
// alu_cmd_parser byte-in / word-out streams.
// master drives bytes and word ready; slave is the parser.
interface alu_cmd_parser_if;

  logic [7:0]  in_tdata_i;
  logic        in_tvalid_i;
  logic        in_tready_o;
  logic [31:0] out_tdata_o;
  logic        out_tvalid_o;
  logic        out_tready_i;
  logic        out_tlast_o;
  logic [2:0]  out_bytes_o;
  logic [7:0]  opcode_o;
  logic        err_o;

  modport master (
    output in_tdata_i, in_tvalid_i, out_tready_i,
    input  in_tready_o, out_tdata_o, out_tvalid_o,
    input  out_tlast_o, out_bytes_o, opcode_o, err_o
  );

  modport slave (
    input  in_tdata_i, in_tvalid_i, out_tready_i,
    output in_tready_o, out_tdata_o, out_tvalid_o,
    output out_tlast_o, out_bytes_o, opcode_o, err_o
  );

endinterface

// File: rtl/alu_cmd_parser_packer.sv
// byte_word_packer: gathers payload bytes into
// little-endian words and holds each until accepted.
module byte_word_packer #(
  parameter int DW = 8,
  parameter int WW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] din,
  input  logic          push,
  input  logic          last,
  input  logic          out_ready,
  output logic          in_ready,
  output logic [WW-1:0] word,
  output logic          word_vld,
  output logic          word_last,
  output logic [2:0]    word_bytes
);

  localparam int LANES = WW / DW;

  logic [2:0]    idx_q;
  logic [WW-1:0] acc_q;
  logic [WW-1:0] acc_ins;
  logic          full;

  assign in_ready = !word_vld | out_ready;
  assign acc_ins  = acc_q | (WW'(din) << (idx_q * DW));
  assign full     = last | (idx_q == 3'(LANES - 1));

  // Insert lanes; publish the word on the completing byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q      <= '0;
      acc_q      <= '0;
      word       <= '0;
      word_vld   <= 1'b0;
      word_last  <= 1'b0;
      word_bytes <= '0;
    end else begin
      if (word_vld && out_ready)
        word_vld <= 1'b0;
      if (push) begin
        if (full) begin
          word       <= acc_ins;
          word_vld   <= 1'b1;
          word_last  <= last;
          word_bytes <= idx_q + 3'd1;
          idx_q      <= '0;
          acc_q      <= '0;
        end else begin
          acc_q <= acc_ins;
          idx_q <= idx_q + 3'd1;
        end
      end
    end
  end

endmodule

// File: rtl/alu_cmd_parser.sv
// alu_cmd_parser: frames UART bytes into command
// packets and streams operand words to the ALU.
module alu_cmd_parser
  import alu_cmd_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int WORD_WIDTH = 32
) (
  input logic             clk,
  input logic             rst,
  alu_cmd_parser_if.slave bus
);

  state_t      state_q, state_d;
  logic [7:0]  op_q;
  logic [7:0]  len_lo_q;
  logic [7:0]  opcode_q;
  logic [15:0] rem_q, rem_d;
  logic        err_q, err_d;

  logic        in_ready;
  logic        in_fire;
  logic [15:0] len;
  logic [15:0] len_m4;
  logic        bad_pkt;
  logic        push;
  logic        last;

  assign in_fire = bus.in_tvalid_i & in_ready;
  assign len     = {bus.in_tdata_i, len_lo_q};
  assign len_m4  = len - 16'(HDR_BYTES);
  assign bad_pkt = !is_valid_opcode(op_q)
                 | ((op_q != OP_ECHO)
                   & ((len < 16'(MIN_ALU_LEN))
                     | (len[1:0] != 2'b00)));
  assign push    = in_fire & (state_q == S_PAYLOAD);
  assign last    = (rem_q == 16'd1);

  // Next state, length countdown and error pulse.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    err_d   = 1'b0;
    if (in_fire) begin
      unique case (state_q)
        S_OPCODE: state_d = S_RSVD;
        S_RSVD:   state_d = S_LEN_LO;
        S_LEN_LO: state_d = S_LEN_HI;
        S_LEN_HI: begin
          rem_d = len_m4;
          if (len < 16'(HDR_BYTES)) begin
            err_d   = 1'b1;
            state_d = S_OPCODE;
          end else if (bad_pkt) begin
            err_d   = 1'b1;
            state_d = (len_m4 != 16'd0)
                    ? S_DRAIN : S_OPCODE;
          end else if (len_m4 == 16'd0) begin
            state_d = S_OPCODE;
          end else begin
            state_d = S_PAYLOAD;
          end
        end
        S_PAYLOAD, S_DRAIN: begin
          rem_d = rem_q - 16'd1;
          if (last)
            state_d = S_OPCODE;
        end
        default: state_d = S_OPCODE;
      endcase
    end
  end

  // State, countdown and error registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_OPCODE;
      rem_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
    end
  end

  // Header field latches; opcode_o moves only at LEN_HI.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= '0;
      len_lo_q <= '0;
      opcode_q <= '0;
    end else if (in_fire) begin
      if (state_q == S_OPCODE)
        op_q <= bus.in_tdata_i;
      if (state_q == S_LEN_LO)
        len_lo_q <= bus.in_tdata_i;
      if (state_q == S_LEN_HI)
        opcode_q <= op_q;
    end
  end

  logic [WORD_WIDTH-1:0] word;
  logic                  word_vld;
  logic                  word_last;
  logic [2:0]            word_bytes;

  byte_word_packer #(
    .DW(DATA_WIDTH),
    .WW(WORD_WIDTH)
  ) u_packer (
    .clk       (clk),
    .rst       (rst),
    .din       (bus.in_tdata_i),
    .push      (push),
    .last      (last),
    .out_ready (bus.out_tready_i),
    .in_ready  (in_ready),
    .word      (word),
    .word_vld  (word_vld),
    .word_last (word_last),
    .word_bytes(word_bytes)
  );

  assign bus.in_tready_o  = in_ready;
  assign bus.out_tdata_o  = word;
  assign bus.out_tvalid_o = word_vld;
  assign bus.out_tlast_o  = word_last;
  assign bus.out_bytes_o  = word_bytes;
  assign bus.opcode_o     = opcode_q;
  assign bus.err_o        = err_q;

endmodule

// File: tb/tb_alu_cmd_parser.sv
// tb_alu_cmd_parser: directed packets checked against
// a packet-level model plus literal word values.
module tb_alu_cmd_parser;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_cmd_parser_if bus();

  alu_cmd_parser dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  typedef logic [7:0] bq_t[$];

  typedef struct {
    logic [31:0] d;
    logic        l;
    logic [2:0]  n;
    logic [7:0]  op;
  } wrd_t;

  wrd_t exp_q[$];
  wrd_t got_q[$];
  int   errs = 0;
  int   checks = 0;
  int   err_pulses = 0;
  int   exp_err = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %h expected %h",
               nm, act, req);
    end
  endtask

  // Packet-level expectation from the framing rules.
  task automatic model_pkt(input bq_t b);
    int          len;
    logic [7:0]  op;
    logic [31:0] w;
    int          n;
    op  = b[0];
    len = {b[3], b[2]};
    if (len < 4
        || !(op inside {8'hEC, 8'hA0, 8'hA1, 8'hA2})
        || (op != 8'hEC
            && (len < 12 || len % 4 != 0))) begin
      exp_err++;
      return;
    end
    for (int i = 4; i < len; i += 4) begin
      w = '0;
      n = 0;
      for (int k = 0; k < 4 && i + k < len; k++) begin
        w[8*k +: 8] = b[i+k];
        n++;
      end
      exp_q.push_back('{w, (i + 4 >= len),
                        3'(n), op});
    end
  endtask

  // Per-cycle compare on every accepted word.
  always @(negedge clk) begin
    wrd_t e;
    if (!rst) begin
      if (bus.err_o)
        err_pulses++;
      if (bus.out_tvalid_o && bus.out_tready_i) begin
        got_q.push_back('{bus.out_tdata_o,
                          bus.out_tlast_o,
                          bus.out_bytes_o,
                          bus.opcode_o});
        if (exp_q.size() == 0) begin
          checks++;
          errs++;
          $display("FAIL unexpected_word: got %h",
                   bus.out_tdata_o);
        end else begin
          e = exp_q.pop_front();
          chk("word_data", bus.out_tdata_o, e.d);
          chk("word_last", 32'(bus.out_tlast_o),
              32'(e.l));
          chk("word_bytes", 32'(bus.out_bytes_o),
              32'(e.n));
          chk("word_opcode", 32'(bus.opcode_o),
              32'(e.op));
        end
      end
    end
  end

  task automatic send(input bq_t b);
    logic ok;
    int   n;
    foreach (b[i]) begin
      bus.in_tdata_i  = b[i];
      bus.in_tvalid_i = 1'b1;
      n = 0;
      forever begin
        @(negedge clk);
        ok = bus.in_tready_o;
        @(posedge clk);
        #1;
        if (ok) break;
        n++;
        if (n > 200) begin
          checks++;
          errs++;
          $display("FAIL byte_timeout: byte %0d", i);
          break;
        end
      end
    end
    bus.in_tvalid_i = 1'b0;
  endtask

  task automatic settle();
    int n = 0;
    while ((exp_q.size() != 0 || bus.out_tvalid_o)
           && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("drained", 32'(exp_q.size()), 32'd0);
    chk("err_count", 32'(err_pulses), 32'(exp_err));
  endtask

  initial begin
    bq_t  a, b;
    int   g0, e0;
    time  t0;
    logic hit;

    bus.in_tdata_i   = '0;
    bus.in_tvalid_i  = 1'b0;
    bus.out_tready_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_tvalid", 32'(bus.out_tvalid_o), 0);
    chk("rst_tdata", bus.out_tdata_o, 0);
    chk("rst_opcode", 32'(bus.opcode_o), 0);
    chk("rst_bytes", 32'(bus.out_bytes_o), 0);
    chk("rst_in_tready", 32'(bus.in_tready_o), 1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // ADD len=12
    g0 = got_q.size();
    a = '{8'hA0, 8'h00, 8'h0C, 8'h00,
          8'h04, 8'h03, 8'h02, 8'h01,
          8'h08, 8'h07, 8'h06, 8'h05};
    model_pkt(a);
    send(a);
    settle();
    chk("add_nwords", 32'(got_q.size() - g0), 2);
    if (got_q.size() >= g0 + 2) begin
      chk("add_w0", got_q[g0].d, 32'h01020304);
      chk("add_w0_last", 32'(got_q[g0].l), 0);
      chk("add_w1", got_q[g0+1].d, 32'h05060708);
      chk("add_w1_last", 32'(got_q[g0+1].l), 1);
      chk("add_op", 32'(got_q[g0+1].op), 32'hA0);
    end

    // ECHO len=7 then MUL back-to-back
    g0 = got_q.size();
    a = '{8'hEC, 8'h00, 8'h07, 8'h00,
          8'h41, 8'h42, 8'h43};
    b = '{8'hA1, 8'h00, 8'h0C, 8'h00,
          8'h11, 8'h22, 8'h33, 8'h44,
          8'h55, 8'h66, 8'h77, 8'h88};
    model_pkt(a);
    model_pkt(b);
    t0 = $time;
    send({a, b});
    chk("b2b_cycles", 32'(($time - t0) / 10), 19);
    settle();
    if (got_q.size() >= g0 + 1) begin
      chk("echo_w", got_q[g0].d, 32'h00434241);
      chk("echo_bytes", 32'(got_q[g0].n), 3);
      chk("echo_last", 32'(got_q[g0].l), 1);
    end

    // Backpressure on ADD len=16
    g0 = got_q.size();
    a = '{8'hA0, 8'h00, 8'h10, 8'h00,
          8'h01, 8'h02, 8'h03, 8'h04,
          8'h05, 8'h06, 8'h07, 8'h08,
          8'h09, 8'h0A, 8'h0B, 8'h0C};
    model_pkt(a);
    fork
      send(a);
      begin
        hit = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
          @(negedge clk);
          hit = bus.out_tvalid_o & bus.out_tready_i;
        end
        chk("first_word_seen", 32'(hit), 1);
        @(posedge clk);
        #1;
        bus.out_tready_i = 1'b0;
        repeat (20) begin
          @(negedge clk);
          if (bus.out_tvalid_o)
            chk("stall_in_tready",
                32'(bus.in_tready_o), 0);
        end
        chk("stall_pending", 32'(bus.out_tvalid_o), 1);
        @(posedge clk);
        #1;
        bus.out_tready_i = 1'b1;
      end
    join
    settle();
    chk("bp_nwords", 32'(got_q.size() - g0), 3);

    // Bad opcode, drained, then DIV
    e0 = err_pulses;
    g0 = got_q.size();
    a = '{8'h55, 8'h00, 8'h08, 8'h00,
          8'hD1, 8'hD2, 8'hD3, 8'hD4};
    b = '{8'hA2, 8'h00, 8'h0C, 8'h00,
          8'hAA, 8'hBB, 8'hCC, 8'hDD,
          8'h01, 8'h00, 8'h00, 8'h00};
    model_pkt(a);
    model_pkt(b);
    send({a, b});
    settle();
    chk("bad_err_once", 32'(err_pulses - e0), 1);
    if (got_q.size() >= g0 + 1)
      chk("div_w0", got_q[g0].d, 32'hDDCCBBAA);

    // ADD len=10 drained, then ECHO len=6
    e0 = err_pulses;
    g0 = got_q.size();
    a = '{8'hA0, 8'h00, 8'h0A, 8'h00,
          8'h01, 8'h02, 8'h03, 8'h04,
          8'h05, 8'h06};
    b = '{8'hEC, 8'h00, 8'h06, 8'h00,
          8'h61, 8'h62};
    model_pkt(a);
    model_pkt(b);
    send({a, b});
    settle();
    chk("len10_err", 32'(err_pulses - e0), 1);
    if (got_q.size() >= g0 + 1) begin
      chk("len10_echo", got_q[g0].d, 32'h00006261);
      chk("len10_bytes", 32'(got_q[g0].n), 2);
    end

    // len=2, next byte is an opcode
    e0 = err_pulses;
    g0 = got_q.size();
    a = '{8'hEC, 8'h00, 8'h02, 8'h00};
    b = '{8'hEC, 8'h00, 8'h05, 8'h00, 8'h77};
    model_pkt(a);
    model_pkt(b);
    send({a, b});
    settle();
    chk("len2_err", 32'(err_pulses - e0), 1);
    if (got_q.size() >= g0 + 1)
      chk("len2_echo", got_q[g0].d, 32'h00000077);

    // Reset after 5 of 8 ADD payload bytes
    exp_q.push_back('{32'h14131211, 1'b0,
                      3'd4, 8'hA0});
    a = '{8'hA0, 8'h00, 8'h0C, 8'h00,
          8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
    send(a);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_tvalid", 32'(bus.out_tvalid_o), 0);
    chk("mid_tlast", 32'(bus.out_tlast_o), 0);
    chk("mid_tdata", bus.out_tdata_o, 0);
    chk("mid_bytes", 32'(bus.out_bytes_o), 0);
    chk("mid_opcode", 32'(bus.opcode_o), 0);
    chk("mid_err", 32'(bus.err_o), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    g0 = got_q.size();
    a = '{8'hEC, 8'h00, 8'h05, 8'h00, 8'h99};
    model_pkt(a);
    send(a);
    settle();
    if (got_q.size() >= g0 + 1) begin
      chk("post_rst_w", got_q[g0].d, 32'h00000099);
      chk("post_rst_bytes", 32'(got_q[g0].n), 1);
    end
    chk("post_rst_nwords", 32'(got_q.size() - g0), 1);

    $display("Result: errors=%0d of %0d checks",
             errs, checks);
    $finish;
  end

endmodule
